sprite_word_receiver: RTL
=========================

# sprite_word_receiver

Consumer end of the 32-bit sprite command word produced by the button-driven coordinate generator. It registers the free-running word, detects changes and range-checks the coordinates. It then defers each accepted update to the next frame boundary and commits it to the sprite register bank through a write/acknowledge handshake, holding the decoded fields for the rest of the video pipeline. It sits between the input/coordinate logic and the sprite register file, one instance per controllable sprite.

## Interface
Parameters:
- REG_INDEX, 5'd1: sprite register-bank address written by this instance
- X_MAX, 620: largest legal x coordinate
- Y_MAX, 460: largest legal y coordinate
- ACK_TIMEOUT, 15: cycles in WRITE without wr_ack before abort (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_word  in  32  sprite word {active[31:29], x[28:19], y[18:9], offset[8:0]}, may change any cycle
- new_frame  in  1  one-cycle pulse at frame boundary (vsync)
- wr_ack  in  1  register-bank acknowledge
- wr_en  out  1  write request, held until acknowledged or timed out
- wr_addr  out  5  always REG_INDEX
- wr_data  out  32  word being written
- sprite_x  out  10  last committed x
- sprite_y  out  10  last committed y
- sprite_offset  out  9  last committed memory offset
- sprite_active  out  3  last committed active/sprite-type field
- range_err  out  1  one-cycle pulse: word dropped, coordinate out of range
- timeout_err  out  1  one-cycle pulse: write aborted, no ack
- busy  out  1  high whenever state is not IDLE

## Operation
- in_word registered into in_q every cycle; FSM acts only on in_q. last_word holds the last word consumed; change = (in_q != last_word).
- IDLE: on change, the FSM range-checks in_q. If x > X_MAX or y > Y_MAX, it pulses range_err, sets last_word to in_q and stays IDLE. Otherwise it sets pend_word and last_word to in_q and moves to PENDING.
- PENDING: new_frame high moves to WRITE with pend_word. With new_frame low, a legal change replaces pend_word and last_word (latest wins, coalescing). An illegal change pulses range_err and keeps pend_word. A change coincident with new_frame is not absorbed; it is seen in IDLE after the write.
- WRITE: wr_en=1, wr_data=pend_word, timer counts cycles.
  - wr_ack sampled high: sprite_* load from pend_word, wr_en drops, go IDLE.
  - Timer reaches ACK_TIMEOUT: timeout_err pulses, wr_en drops, last_word cleared to 0 (current word retriggers), outputs unchanged, go IDLE.
- Changes during WRITE are ignored; they are detected in IDLE via last_word.
- Comparisons are unsigned; bounds are inclusive; offset and active fields pass through unchecked.
- Reset values: all outputs 0, state IDLE, in_q/last_word/pend_word/timer 0. Reset mid-WRITE drops wr_en on the next edge with no error pulse.

## Timing
- All outputs registered.
- in_word change before edge E0 → in_q at E0 → PENDING after E1 (2-cycle capture latency).
- new_frame sampled at edge Ek in PENDING → wr_en high from Ek.
- wr_ack may be high in the first wr_en cycle; ack sampled at Ea → wr_en low and sprite_* valid from Ea. Minimum commit is 2 cycles after new_frame.
- Timeout: wr_en high exactly ACK_TIMEOUT cycles, timeout_err coincides with wr_en falling.
- Ack arriving after timeout or while IDLE is ignored.
- new_frame while IDLE or WRITE is ignored.

## Structure
- Shared package sprite_pkg holds:
  - field positions: ACT 31:29, X 28:19, Y 18:9, OFF 8:0
  - widths: COORD_W=10, OFF_W=9, ACT_W=3
  - FSM state typedef IDLE/PENDING/WRITE
- One sub-module, sprite_field_unpack: combinational word → x/y/offset/active plus in_range flag against X_MAX/Y_MAX. It is reused by the bank and the renderer.

## Test plan
- Reset, then in_word=0x23206400 (x=100, y=50, act=1), new_frame 5 cycles later, wr_ack immediate → one wr_en cycle, wr_data=0x23206400, wr_addr=1, sprite_x=100, sprite_y=50, busy low afterward.
- in_word=0x33680000 (x=621) → single range_err pulse, no wr_en, sprite_* unchanged; holding the word produces no further pulses.
- In PENDING, x steps 100→101→102 before new_frame → exactly one write, wr_data x field=102.
- wr_ack held low → wr_en high for exactly 15 cycles, then timeout_err. The next new_frame with the same in_word writes it again.
- new_frame and an in_word change in the same cycle → first write carries the old word, a second write carries the new word at the following new_frame.
- reset asserted during WRITE → wr_en 0 next cycle, all outputs 0, no error pulses.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command word: field positions, widths and
// the receiver FSM state type.
package sprite_pkg;

    localparam int WORD_W  = 32;
    localparam int COORD_W = 10;
    localparam int OFF_W   = 9;
    localparam int ACT_W   = 3;

    // Word layout: {active, x, y, offset}
    localparam int ACT_HI = 31;
    localparam int ACT_LO = 29;
    localparam int X_HI   = 28;
    localparam int X_LO   = 19;
    localparam int Y_HI   = 18;
    localparam int Y_LO   = 9;
    localparam int OFF_HI = 8;
    localparam int OFF_LO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WRITE   = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_field_unpack.sv
// Combinational split of a sprite word into its fields, plus an inclusive
// unsigned bounds check of the coordinates.
module sprite_field_unpack
    import sprite_pkg::*;
#(
    parameter int X_MAX = 620,
    parameter int Y_MAX = 460
) (
    input  logic [WORD_W-1:0]  word,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [OFF_W-1:0]   offset,
    output logic [ACT_W-1:0]   active,
    output logic               in_range
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

    // NOTE: continuous assigns cover every output on every path, so no latch can be inferred.
    assign x        = word[X_HI:X_LO];
    assign y        = word[Y_HI:Y_LO];
    assign offset   = word[OFF_HI:OFF_LO];
    assign active   = word[ACT_HI:ACT_LO];
    assign in_range = (x <= X_LIM) && (y <= Y_LIM);

endmodule

// File: rtl/sprite_word_receiver.sv
// Receives the free-running sprite word, defers legal updates to the next frame
// boundary and commits them to the sprite register bank via write/ack.
module sprite_word_receiver
    import sprite_pkg::*;
#(
    parameter logic [4:0] REG_INDEX   = 5'd1,
    parameter int         X_MAX       = 620,
    parameter int         Y_MAX       = 460,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               new_frame,
    input  logic               wr_ack,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic [COORD_W-1:0] sprite_x,
    output logic [COORD_W-1:0] sprite_y,
    output logic [OFF_W-1:0]   sprite_offset,
    output logic [ACT_W-1:0]   sprite_active,
    output logic               range_err,
    output logic               timeout_err,
    output logic               busy
);

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_e              state;
    logic [WORD_W-1:0]   in_q;
    logic [WORD_W-1:0]   last_word;
    logic [WORD_W-1:0]   pend_word;
    logic [7:0]          timer;
    logic                change;

    logic [WORD_W-1:0]   unpack_word;
    logic [COORD_W-1:0]  f_x;
    logic [COORD_W-1:0]  f_y;
    logic [OFF_W-1:0]    f_offset;
    logic [ACT_W-1:0]    f_active;
    logic                in_range;

    assign change = (in_q != last_word);

    // One unpacker serves both jobs: range-checking arrivals and decoding the committed word.
    assign unpack_word = (state == WRITE) ? pend_word : in_q;

    sprite_field_unpack #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_unpack (
        .word     (unpack_word),
        .x        (f_x),
        .y        (f_y),
        .offset   (f_offset),
        .active   (f_active),
        .in_range (in_range)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_q          <= '0;
            last_word     <= '0;
            pend_word     <= '0;
            timer         <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            sprite_x      <= '0;
            sprite_y      <= '0;
            sprite_offset <= '0;
            sprite_active <= '0;
            range_err     <= 1'b0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            in_q        <= in_word;
            wr_addr     <= REG_INDEX;
            range_err   <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (change) begin
                        last_word <= in_q;
                        if (in_range) begin
                            pend_word <= in_q;
                            state     <= PENDING;
                            busy      <= 1'b1;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end

                PENDING: begin
                    // A change arriving with new_frame stays unconsumed and is picked up after the write.
                    if (new_frame) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_data <= pend_word;
                        timer   <= '0;
                    end else if (change) begin
                        last_word <= in_q;
                        if (in_range) begin
                            pend_word <= in_q;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (wr_ack) begin
                        sprite_x      <= f_x;
                        sprite_y      <= f_y;
                        sprite_offset <= f_offset;
                        sprite_active <= f_active;
                        wr_en         <= 1'b0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        // Clearing last_word makes the still-present word retrigger a write.
                        timeout_err <= 1'b1;
                        wr_en       <= 1'b0;
                        last_word   <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
